btn_debounce: RTL and testbench
===============================

BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 SHALL have parameter N_BTN, default 4, number of independent active-high pushbutton inputs (1..16).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 500_000, consecutive stable cycles needed to accept a level change (10 ms at 50 MHz; legal minimum 2).
REQ-003 SHALL have parameter LONG_CYCLES, default 50_000_000, accepted-press hold time that raises a long-press event (1 s at 50 MHz; SHALL exceed DEBOUNCE_CYCLES).
REQ-004 SHALL have port clk, input, 1, the single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-006 SHALL have port btn_raw, input, N_BTN, asynchronous bouncing pushbutton pins, 1 = pressed.
REQ-007 SHALL have port btn_level, output, N_BTN, debounced registered level per button.
REQ-008 SHALL have port btn_press, output, N_BTN, one-cycle pulse when btn_level rises.
REQ-009 SHALL have port btn_release, output, N_BTN, one-cycle pulse when btn_level falls.
REQ-010 SHALL have port btn_long, output, N_BTN, one-cycle pulse on long-press detection (see Configuration).

Function
REQ-011 Each bit of btn_raw SHALL pass through a two-flop synchronizer before any other use; channels SHALL be fully independent.
REQ-012 Each channel SHALL run a four-state FSM: IDLE (stable released), PRESS_WAIT, HELD (stable pressed), RELEASE_WAIT.
REQ-013 IDLE -> PRESS_WAIT when the synchronized input = 1; HELD -> RELEASE_WAIT when it = 0; the debounce counter SHALL be cleared on entering either wait state.
REQ-014 In a wait state the counter SHALL increment each cycle the synchronized input keeps the new value; a single cycle of the old value SHALL return the FSM to its prior stable state with no output event.
REQ-015 PRESS_WAIT -> HELD when the counter reaches DEBOUNCE_CYCLES-1 with input still 1; RELEASE_WAIT -> IDLE likewise with input 0.
REQ-016 Total latency from a clean btn_raw edge to the btn_level change SHALL be exactly 2 + DEBOUNCE_CYCLES clk cycles.
REQ-017 btn_press/btn_release SHALL assert in the same cycle btn_level changes and SHALL deassert the next cycle; never both in one cycle per channel.
REQ-018 Counter width SHALL be $clog2(max(DEBOUNCE_CYCLES, LONG_CYCLES)+1); counters SHALL saturate, never wrap.
REQ-019 Pulses on different channels in the same cycle SHALL all be reported independently.

Reset
REQ-020 While rst_n = 0 at a clk edge: synchronizers, counters = 0; FSMs = IDLE; btn_level, btn_press, btn_release, btn_long = 0.
REQ-021 Reset asserted mid-bounce or mid-hold SHALL discard the pending transition and SHALL emit no release pulse; a button still held after reset SHALL be re-accepted via full debounce.

Configuration
REQ-022 Macro BTN_LONG_PRESS_EN defined: in HELD a hold counter SHALL count from the HELD entry cycle; at LONG_CYCLES-1 btn_long SHALL pulse once per press; the counter saturates until the FSM leaves HELD or RELEASE_WAIT returns to HELD (no re-pulse).
REQ-023 Macro undefined: no hold counter SHALL be synthesized and btn_long SHALL be tied to 0.

Structure
REQ-024 Shared package btn_pkg SHALL hold the FSM state typedef (IDLE, PRESS_WAIT, HELD, RELEASE_WAIT) and default timing constants for 50 MHz.
REQ-025 Per-button logic SHALL be a sub-module btn_debounce_ch (synchronizer, FSM, counters), instantiated N_BTN times by a generate loop in btn_debounce.

Verification (bench params: N_BTN=2, DEBOUNCE_CYCLES=4, LONG_CYCLES=20)
REQ-026 Clean press on bit 0 at cycle 0 -> btn_level[0]=1 and btn_press[0]=1 at cycle 6 only; btn_press[0]=0 at cycle 7.
REQ-027 Bounce 1,0,1,0 (one cycle each) then steady 1 -> exactly one btn_press pulse, 6 cycles after steady 1 begins.
REQ-028 Press held 30 cycles with BTN_LONG_PRESS_EN -> btn_long[0] single pulse 19 cycles after btn_press[0]; without the macro btn_long stays 0.
REQ-029 Both bits pressed in the same cycle -> btn_press = 2'b11 in one cycle; release of bit 1 only -> btn_release = 2'b10.
REQ-030 rst_n low for 1 cycle while btn_level[0]=1 and raw still 1 -> all outputs 0 with no btn_release pulse, then btn_press[0] again 6 cycles after rst_n returns high.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared types and default timing for the pushbutton debouncer.
// FSM state encoding, 50 MHz default timing, counter-width helper.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_e;

  // 10 ms debounce and 1 s long press at 50 MHz
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 500_000;
  localparam int unsigned DEF_LONG_CYCLES     = 50_000_000;

  function automatic int unsigned cnt_w(
    input int unsigned a,
    input int unsigned b
  );
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One debounce channel: 2-flop synchronizer, 4-state FSM, counters.
// Ports: clk, rst_n, raw_i -> level_o, press_o, release_o, long_o.
// Long-press hold counter only when BTN_LONG_PRESS_EN is defined.
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_o
);

  localparam int unsigned CW =
    cnt_w(DEBOUNCE_CYCLES, LONG_CYCLES);
  localparam logic [CW-1:0] DMAX =
    CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  btn_state_e    state_q, state_d;
  logic [CW-1:0] dcnt_q, dcnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          rel_q, rel_d;
  logic          in_s;

  assign in_s = sync_q[1];

  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    level_d = level_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_s) begin
          state_d = PRESS_WAIT;
          dcnt_d  = '0;
        end
      end
      PRESS_WAIT: begin
        if (!in_s) begin
          state_d = IDLE;
        end else if (dcnt_q >= DMAX) begin
          state_d = HELD;
          level_d = 1'b1;
          press_d = 1'b1;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      HELD: begin
        if (!in_s) begin
          state_d = RELEASE_WAIT;
          dcnt_d  = '0;
        end
      end
      RELEASE_WAIT: begin
        if (in_s) begin
          state_d = HELD;
        end else if (dcnt_q >= DMAX) begin
          state_d = IDLE;
          level_d = 1'b0;
          rel_d   = 1'b1;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q  <= '0;
      state_q <= IDLE;
      dcnt_q  <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], raw_i};
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = rel_q;

`ifdef BTN_LONG_PRESS_EN
  localparam logic [CW-1:0] LMAX =
    CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0] LPRE =
    CW'(LONG_CYCLES - 2);

  logic [CW-1:0] hcnt_q, hcnt_d;
  logic          long_q, long_d;

  // Value survives a RELEASE_WAIT bounce, so a
  // saturated count cannot pulse a second time.
  always_comb begin
    hcnt_d = hcnt_q;
    long_d = 1'b0;
    if (state_q == PRESS_WAIT && state_d == HELD) begin
      hcnt_d = '0;
    end else if (state_q == HELD && in_s) begin
      if (hcnt_q < LMAX) hcnt_d = hcnt_q + 1'b1;
      if (hcnt_q == LPRE) long_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hcnt_q <= '0;
      long_q <= 1'b0;
    end else begin
      hcnt_q <= hcnt_d;
      long_q <= long_d;
    end
  end

  assign long_o = long_q;
`else
  assign long_o = 1'b0;
`endif

endmodule

// File: rtl/btn_debounce.sv
// Multi-button debouncer: N_BTN independent btn_debounce_ch channels.
// Ports: clk, rst_n, btn_raw -> btn_level/press/release/long; BTN_LONG_PRESS_EN.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int unsigned N_BTN           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_long
);

  for (genvar i = 0; i < int'(N_BTN); i++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .raw_i    (btn_raw[i]),
      .level_o  (btn_level[i]),
      .press_o  (btn_press[i]),
      .release_o(btn_release[i]),
      .long_o   (btn_long[i])
    );
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce (N_BTN=2, DEBOUNCE=4, LONG=20).
// Samples 1 time unit after each rising edge.
module tb_btn_debounce;

  localparam int NB = 2;
  localparam int DC = 4;
  localparam int LC = 20;
`ifdef BTN_LONG_PRESS_EN
  localparam int LONG_EN = 1;
`else
  localparam int LONG_EN = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_press;
  logic [NB-1:0] btn_release;
  logic [NB-1:0] btn_long;

  int n_tests = 0;
  int n_fail  = 0;
  int n_long  = 0;

  always #5 clk = ~clk;

  btn_debounce #(
    .N_BTN          (NB),
    .DEBOUNCE_CYCLES(DC),
    .LONG_CYCLES    (LC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_long   (btn_long)
  );

  task automatic chk(
    input string tag,
    input int    got,
    input int    exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    n_long += $countones(btn_long);
  endtask

  initial begin
    int np, lp, lpos, rp, nr;

    rst_n   = 1'b0;
    btn_raw = '0;
    tick;
    tick;
    chk("rst_level", int'(btn_level), 0);
    chk("rst_events",
        int'({btn_press, btn_release, btn_long}), 0);
    rst_n = 1'b1;
    repeat (3) tick;

    // clean press on bit 0, held 30 cycles
    btn_raw = 2'b01;
    np = 0; lp = -1; lpos = -1;
    for (int k = 0; k < 30; k++) begin
      tick;
      if (btn_press[0]) begin np++; lp = k; end
      if (btn_long[0]) lpos = k;
      if (k == 5)
        chk("t1_lvl_k5", int'(btn_level[0]), 0);
      if (k == 6) begin
        chk("t1_lvl_k6", int'(btn_level[0]), 1);
        chk("t1_prs_k6", int'(btn_press), 1);
      end
      if (k == 7) begin
        chk("t1_prs_k7", int'(btn_press[0]), 0);
        chk("t1_lvl_k7", int'(btn_level[0]), 1);
      end
    end
    chk("t1_npress", np, 1);
    chk("t1_press_at", lp, 6);
    chk("t1_long_at", lpos, (LONG_EN != 0) ? 25 : -1);
    chk("t1_long_cnt", n_long, LONG_EN);

    // clean release
    btn_raw = 2'b00;
    rp = -1;
    for (int k = 0; k < 8; k++) begin
      tick;
      if (btn_release[0]) rp = k;
    end
    chk("t1_rel_at", rp, 6);
    chk("t1_rel_lvl", int'(btn_level), 0);

    // bounce 1,0,1,0 then steady 1
    np = 0; lp = -1;
    for (int k = 0; k < 16; k++) begin
      btn_raw[0] = (k >= 4) || (k % 2 == 0);
      tick;
      if (btn_press[0]) begin np++; lp = k; end
    end
    chk("t2_npress", np, 1);
    chk("t2_press_at", lp, 10);
    btn_raw = 2'b00;
    repeat (8) tick;
    chk("t2_lvl_off", int'(btn_level), 0);

    // both pressed together, then release bit 1
    btn_raw = 2'b11;
    for (int k = 0; k < 8; k++) begin
      tick;
      if (k == 6) begin
        chk("t3_press", int'(btn_press), 3);
        chk("t3_lvl", int'(btn_level), 3);
      end
      if (k == 7) chk("t3_press_k7", int'(btn_press), 0);
    end
    btn_raw = 2'b01;
    for (int k = 0; k < 8; k++) begin
      tick;
      if (k == 6) begin
        chk("t3_rel", int'(btn_release), 2);
        chk("t3_no_press", int'(btn_press), 0);
        chk("t3_lvl_rel", int'(btn_level), 1);
      end
    end

    // reset while bit 0 held
    rst_n = 1'b0;
    tick;
    chk("t4_rst_out",
        int'({btn_level, btn_press, btn_release, btn_long}), 0);
    rst_n = 1'b1;
    nr = 0; lp = -1;
    for (int k = 1; k <= 10; k++) begin
      tick;
      nr += $countones(btn_release);
      if (btn_press[0]) lp = k;
    end
    chk("t4_no_rel", nr, 0);
    chk("t4_press_at", lp, 7);
    chk("t4_lvl", int'(btn_level), 1);
    chk("long_total", n_long, LONG_EN);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
